// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction sequencer: widths, opcodes and FSM states.
package cpu_pkg;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OpNop  = 4'h0;
  localparam logic [OP_W-1:0] OpJmp  = 4'h8;
  localparam logic [OP_W-1:0] OpJz   = 4'h9;
  localparam logic [OP_W-1:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StRead,
    StExec,
    StWrite,
    StHalt
  } state_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= 4'h1) && (op <= 4'h7);
  endfunction

endpackage

// File: rtl/seq_pc.sv
// Program counter: load takes priority over increment; wraps naturally at PC_W bits.
module seq_pc
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches from ROM, sequences RAM read, ALU and RAM write.
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   rom_address,
  output logic              rom_read_enable,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_read_addr,
  output logic [ADDR_W-1:0] ram_write_addr,
  input  logic              ram_ready,
  output logic              alu_enable,
  output logic [OP_W-1:0]   alu_op,
  input  logic              alu_done,
  input  logic              alu_zero,
  output logic              instr_done,
  output logic              halted
);

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic              zero_flag;
  logic [OP_W-1:0]   dec_op;
  logic [PC_W-1:0]   pc;
  logic              pc_inc;
  logic              pc_load;

  // rom_data is only meaningful during DECODE, the cycle after the fetch strobe.
  assign dec_op  = rom_data[DATA_W-1 -: OP_W];
  assign pc_inc  = (state == StDecode);
  assign pc_load = (state == StDecode) &&
                   ((dec_op == OpJmp) || ((dec_op == OpJz) && zero_flag));

  seq_pc u_seq_pc (
    .clk    (clk),
    .reset  (reset),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (rom_data[PC_W-1:0]),
    .pc     (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StFetch;
      ir        <= '0;
      zero_flag <= 1'b0;
    end else begin
      unique case (state)
        StFetch: state <= StDecode;
        StDecode: begin
          ir <= rom_data;
          if (is_alu_op(dec_op))    state <= StRead;
          else if (dec_op == OpHalt) state <= StHalt;
          else                       state <= StFetch;
        end
        StRead: if (ram_ready) state <= StExec;
        StExec: begin
          if (alu_done) begin
            zero_flag <= alu_zero;
            state     <= StWrite;
          end
        end
        StWrite: if (ram_ready) state <= StFetch;
        StHalt:  state <= StHalt;
        default: state <= StFetch;
      endcase
    end
  end

  assign rom_address = pc;

  // Outputs are gated by reset so an asserted reset silences every strobe at once.
  always_comb begin
    rom_read_enable = 1'b0;
    ram_read        = 1'b0;
    ram_write       = 1'b0;
    ram_read_addr   = '0;
    ram_write_addr  = '0;
    alu_enable      = 1'b0;
    alu_op          = '0;
    instr_done      = 1'b0;
    halted          = 1'b0;
    if (!reset) begin
      unique case (state)
        StFetch:  rom_read_enable = 1'b1;
        StDecode: instr_done = !is_alu_op(dec_op);
        StRead: begin
          ram_read      = 1'b1;
          ram_read_addr = ir[ADDR_W-1:0];
        end
        StExec: begin
          alu_enable = 1'b1;
          alu_op     = ir[DATA_W-1 -: OP_W];
        end
        StWrite: begin
          ram_write      = 1'b1;
          ram_write_addr = ir[2*ADDR_W-1:ADDR_W];
          instr_done     = ram_ready;
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
